// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-to-host receiver. Synchronises the raw PS/2 clock and
//            data pins, deframes 11-bit frames (start, 8 data LSB-first, odd
//            parity, stop), validates them and queues accepted scancodes in a
//            fall-through FIFO drained through a valid/ready read port.
// Ports    : clk_i, rst_ni        system clock / async active-low reset
//            ps2_clk_i, ps2_data_i raw asynchronous PS/2 pins
//            rd_data_o/rd_valid_o/rd_ready_i  FIFO read port (pop on valid&ready)
//            count_o              FIFO occupancy
//            frame_err_o          1-cycle pulse on rejected or timed-out frame
//            overflow_o           sticky, valid frame dropped on full FIFO
//            clear_ovf_i          clears overflow_o (a same-cycle set wins)
// Config   : PS2_RX_PARITY_CHECK_EN - when defined, odd parity is enforced;
//            otherwise the parity bit is sampled but ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clear_ovf_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // --------------------------------------------------------------------------
  // Synchronisers. Reset to 1 (idle bus level) so a reset never fakes a fall.
  // --------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // --------------------------------------------------------------------------
  // Deframing FSM with mid-frame timeout
  // --------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok;
  logic          frame_bad;
  logic          timeout_hit;
  logic          stop_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign stop_ok = dat_s2_q & (^{shift_q, parity_q});
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign stop_ok       = dat_s2_q;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    timeout_hit = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A fall with data high is line noise / idle, not a start bit.
        if (fall && !dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_d = dat_s2_q;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d   = ST_IDLE;
          frame_ok  = stop_ok;
          frame_bad = ~stop_ok;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall in the same cycle resets the watchdog, so it takes priority.
    if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d     = ST_IDLE;
      tmo_d       = '0;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      frame_err_o <= frame_bad | timeout_hit;
    end
  end

  // --------------------------------------------------------------------------
  // Scancode FIFO: pointers carry an extra wrap bit to tell full from empty.
  // --------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full;
  logic        pop;
  logic        push_en;
  logic        ovf_set;

  assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign rd_valid_o = (wr_ptr_q != rd_ptr_q);
  assign pop        = rd_valid_o & rd_ready_i;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign push_en    = frame_ok & (~fifo_full | pop);
  assign ovf_set    = frame_ok & fifo_full & ~pop;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (clear_ovf_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
